// File: rtl/reg_read_port_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_read_port_if
// Summary  : Decode-side register file bus: read ports, write-back, load scoreboard.
// Revision : 1.0
// ============================================================================
interface reg_read_port_if #(
  parameter int NREG  = 32,
  parameter int WIDTH = 64
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [AW-1:0]    rd_addr_a;
  logic             rd_en_a;
  logic [WIDTH-1:0] rd_data_a;
  logic [AW-1:0]    rd_addr_b;
  logic             rd_en_b;
  logic [WIDTH-1:0] rd_data_b;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             pend_set;
  logic [AW-1:0]    pend_addr;
  logic             stall;
  logic [CW-1:0]    pend_count;

  modport master (
    output rd_addr_a, rd_en_a, rd_addr_b, rd_en_b,
    output wr_en, wr_addr, wr_data, pend_set, pend_addr,
    input  rd_data_a, rd_data_b, stall, pend_count
  );

  modport slave (
    input  rd_addr_a, rd_en_a, rd_addr_b, rd_en_b,
    input  wr_en, wr_addr, wr_data, pend_set, pend_addr,
    output rd_data_a, rd_data_b, stall, pend_count
  );
endinterface
`default_nettype wire

// File: rtl/reg_read_port.sv
`default_nettype none
// ============================================================================
// Module   : reg_read_port
// Summary  : 32x64 register file with two bypassed read ports and load-use stall.
// Revision : 1.0
// ============================================================================
module reg_read_port #(
  parameter int NREG     = 32,
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  reg_read_port_if.slave   bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);
  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [NREG-1:0]  pend_q;
  logic [NREG-1:0]  pend_d;
  logic             wr_ok;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             stall_a;
  logic             stall_b;
  logic [CW-1:0]    count;

  assign wr_ok = bus.wr_en && (bus.wr_addr != ZERO_A);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Set is applied after clear so a new load on the retiring register stays pending.
  always_comb begin
    pend_d = pend_q;
    if (bus.wr_en) begin
      pend_d[bus.wr_addr] = 1'b0;
    end
    if (bus.pend_set && (bus.pend_addr != ZERO_A)) begin
      pend_d[bus.pend_addr] = 1'b1;
    end
    pend_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  function automatic logic [WIDTH-1:0] read_mux(
    input logic [AW-1:0]    addr,
    input logic             wen,
    input logic [AW-1:0]    waddr,
    input logic [WIDTH-1:0] wdata,
    input logic [WIDTH-1:0] stored
  );
    if (addr == ZERO_A) begin
      return '0;
    end else if (wen && (waddr == addr)) begin
      return wdata;
    end else begin
      return stored;
    end
  endfunction

  always_comb begin
    data_a = read_mux(bus.rd_addr_a, bus.wr_en, bus.wr_addr, bus.wr_data,
                      regs_q[bus.rd_addr_a]);
    data_b = read_mux(bus.rd_addr_b, bus.wr_en, bus.wr_addr, bus.wr_data,
                      regs_q[bus.rd_addr_b]);
  end

  // A write retiring this cycle feeds the operand through the bypass, so no hazard.
  always_comb begin
    stall_a = bus.rd_en_a && pend_q[bus.rd_addr_a]
              && !(bus.wr_en && (bus.wr_addr == bus.rd_addr_a));
    stall_b = bus.rd_en_b && pend_q[bus.rd_addr_b]
              && !(bus.wr_en && (bus.wr_addr == bus.rd_addr_b));
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < NREG; i++) begin
      count = count + CW'(pend_q[i]);
    end
  end

  // Reset also masks the bypass path so outputs read zero even with wr_en high.
  assign bus.rd_data_a  = reset ? data_a : '0;
  assign bus.rd_data_b  = reset ? data_b : '0;
  assign bus.stall      = reset && (stall_a || stall_b);
  assign bus.pend_count = reset ? count : '0;
endmodule
`default_nettype wire

// File: tb/tb_reg_read_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_read_port
// Summary  : Directed stimulus with queued expectations checked by a monitor.
// Revision : 1.0
// ============================================================================
module tb_reg_read_port;
  logic clk;
  logic reset;

  reg_read_port_if #(.NREG(32), .WIDTH(64)) bus ();

  reg_read_port #(.NREG(32), .WIDTH(64), .ZERO_REG(31)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  m;
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic [5:0]  c;
  } exp_t;

  localparam logic [3:0] MA = 4'b1000;
  localparam logic [3:0] MB = 4'b0100;
  localparam logic [3:0] MS = 4'b0010;
  localparam logic [3:0] MC = 4'b0001;
  localparam logic [3:0] MALL = 4'b1111;

  exp_t  exp_q [$];
  string nm_q  [$];
  int    total = 0;
  int    bad   = 0;
  exp_t  mon_e;
  string mon_n;

  // Monitor: every negedge with a queued expectation pops and compares it.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = nm_q.pop_front();
      if (mon_e.m[3]) begin
        total++;
        if (bus.rd_data_a !== mon_e.a) begin
          bad++;
          $display("FAIL %s rd_data_a got=%h exp=%h", mon_n, bus.rd_data_a, mon_e.a);
        end
      end
      if (mon_e.m[2]) begin
        total++;
        if (bus.rd_data_b !== mon_e.b) begin
          bad++;
          $display("FAIL %s rd_data_b got=%h exp=%h", mon_n, bus.rd_data_b, mon_e.b);
        end
      end
      if (mon_e.m[1]) begin
        total++;
        if (bus.stall !== mon_e.s) begin
          bad++;
          $display("FAIL %s stall got=%b exp=%b", mon_n, bus.stall, mon_e.s);
        end
      end
      if (mon_e.m[0]) begin
        total++;
        if (bus.pend_count !== mon_e.c) begin
          bad++;
          $display("FAIL %s pend_count got=%0d exp=%0d", mon_n, bus.pend_count, mon_e.c);
        end
      end
    end
  end

  task automatic cyc(input logic [4:0] ra, input logic ea,
                     input logic [4:0] rb, input logic eb,
                     input logic we, input logic [4:0] wa, input logic [63:0] wd,
                     input logic ps, input logic [4:0] pa);
    @(posedge clk);
    #1;
    bus.rd_addr_a = ra;
    bus.rd_en_a   = ea;
    bus.rd_addr_b = rb;
    bus.rd_en_b   = eb;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.pend_set  = ps;
    bus.pend_addr = pa;
  endtask

  task automatic expect_out(input string nm, input logic [3:0] m,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic s, input logic [5:0] c);
    exp_t e;
    e.m = m; e.a = a; e.b = b; e.s = s; e.c = c;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  function automatic logic [63:0] wb_val(input int i);
    return 64'hA5A5_0000_0000_0000 + 64'(i);
  endfunction

  localparam logic [63:0] X5V = 64'h0123_4567_89AB_CDEF;

  initial begin
    reset = 1'b0;
    bus.rd_addr_a = '0; bus.rd_en_a = 1'b0;
    bus.rd_addr_b = '0; bus.rd_en_b = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.pend_set = 1'b0; bus.pend_addr = '0;

    // In reset, a write to X5 must neither bypass nor land.
    cyc(5'd5, 1'b1, 5'd7, 1'b1, 1'b1, 5'd5, 64'hDEAD, 1'b1, 5'd7);
    expect_out("reset_hold", MALL, 64'd0, 64'd0, 1'b0, 6'd0);
    cyc(5'd5, 1'b0, 5'd7, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    reset = 1'b1;
    expect_out("reset_release", MALL, 64'd0, 64'd0, 1'b0, 6'd0);

    for (int i = 0; i < 16; i++) begin
      cyc(5'(i), 1'b0, 5'(i + 16), 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
      expect_out($sformatf("zero_read%0d", i), MALL, 64'd0, 64'd0, 1'b0, 6'd0);
    end

    cyc(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, X5V, 1'b0, 5'd0);
    expect_out("x5_bypass", MA | MC, X5V, 64'd0, 1'b0, 6'd0);
    cyc(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    expect_out("x5_stored", MA, X5V, 64'd0, 1'b0, 6'd0);

    cyc(5'd31, 1'b1, 5'd31, 1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0);
    expect_out("xzr_wr_bypass", MA | MB, 64'd0, 64'd0, 1'b0, 6'd0);
    cyc(5'd31, 1'b1, 5'd31, 1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd31);
    expect_out("xzr_stored", MALL, 64'd0, 64'd0, 1'b0, 6'd0);
    cyc(5'd31, 1'b1, 5'd31, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    expect_out("xzr_never_pend", MS | MC, 64'd0, 64'd0, 1'b0, 6'd0);

    cyc(5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
    expect_out("x7_set_cycle", MS | MC, 64'd0, 64'd0, 1'b0, 6'd0);
    cyc(5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    expect_out("x7_stall", MB | MS | MC, 64'd0, 64'd0, 1'b1, 6'd1);
    cyc(5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    expect_out("x7_unused", MS | MC, 64'd0, 64'd0, 1'b0, 6'd1);
    cyc(5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 64'h42, 1'b0, 5'd0);
    expect_out("x7_retire", MB | MS | MC, 64'd0, 64'h42, 1'b0, 6'd1);
    cyc(5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    expect_out("x7_after", MB | MS | MC, 64'd0, 64'h42, 1'b0, 6'd0);

    cyc(5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 64'hAA, 1'b1, 5'd9);
    expect_out("x9_set_clr", MA | MS | MC, 64'hAA, 64'd0, 1'b0, 6'd0);
    cyc(5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    expect_out("x9_set_wins", MA | MS | MC, 64'hAA, 64'd0, 1'b1, 6'd1);
    cyc(5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9);
    expect_out("x9_reset_again", MS | MC, 64'd0, 64'd0, 1'b0, 6'd1);
    cyc(5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    expect_out("x9_no_double", MC, 64'd0, 64'd0, 1'b0, 6'd1);
    cyc(5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 64'h99, 1'b0, 5'd0);
    expect_out("x9_retire", MA | MS | MC, 64'h99, 64'd0, 1'b0, 6'd1);

    for (int i = 1; i <= 31; i++) begin
      cyc(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'(i));
      expect_out($sformatf("pend%0d", i), MS | MC, 64'd0, 64'd0, 1'b0, 6'(i - 1));
    end
    cyc(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    expect_out("pend_full", MC, 64'd0, 64'd0, 1'b0, 6'd30);

    for (int i = 1; i <= 30; i++) begin
      cyc(5'(i), 1'b1, 5'(i + 1), 1'b1, 1'b1, 5'(i), wb_val(i), 1'b0, 5'd0);
      expect_out($sformatf("wb%0d", i), MA | MS | MC, wb_val(i), 64'd0,
                 (i < 30), 6'(31 - i));
    end
    cyc(5'd5, 1'b1, 5'd30, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    expect_out("wb_done", MALL, wb_val(5), wb_val(30), 1'b0, 6'd0);

    cyc(5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 64'h55, 1'b1, 5'd4);
    expect_out("x3_write", MA | MC, 64'h55, 64'd0, 1'b0, 6'd0);
    cyc(5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    expect_out("x3_hold", MALL, 64'h55, wb_val(4), 1'b1, 6'd1);
    // Reset lands between edges while a write and a load set are presented.
    cyc(5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 5'd3, 64'h77, 1'b1, 5'd5);
    reset = 1'b0;
    expect_out("async_reset", MALL, 64'd0, 64'd0, 1'b0, 6'd0);
    cyc(5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 5'd3, 64'h77, 1'b1, 5'd5);
    expect_out("reset_edge", MALL, 64'd0, 64'd0, 1'b0, 6'd0);
    cyc(5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    reset = 1'b1;
    expect_out("post_reset", MALL, 64'd0, 64'd0, 1'b0, 6'd0);
    cyc(5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    expect_out("post_reset_x5", MALL, 64'd0, 64'd0, 1'b0, 6'd0);

    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
